// File: rtl/ac_pkg.sv
// Shared accumulator definitions for the datapath, ALU and the AC register.
// The flag struct is only consumed when AC_FLAGS_EN is defined.
package ac_pkg;

  localparam int unsigned AC_WIDTH     = 32;
  localparam logic [31:0] AC_RESET_VAL = 32'h0000_0000;

  typedef logic [AC_WIDTH-1:0] ac_word_t;

  // Status flags that travel alongside the accumulator value.
  typedef struct packed {
    logic zero;
    logic neg;
    logic changed;
  } ac_flags_t;

endpackage : ac_pkg

// File: rtl/ac_flag_gen.sv
// Combinational status-flag generator for the accumulator (zero, sign, changed).
// Exists only when AC_FLAGS_EN is defined.
`ifdef AC_FLAGS_EN
module ac_flag_gen
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH = AC_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] prev_i,
  output ac_flags_t        flags_c
);

  // Flags describe the value about to be captured, relative to the one held now.
  always_comb begin
    flags_c         = '0;
    flags_c.zero    = (value_i == '0);
    flags_c.neg     = value_i[WIDTH-1];
    flags_c.changed = (value_i != prev_i);
  end

endmodule : ac_flag_gen
`endif

// File: rtl/accumulator_reg.sv
// Accumulator (AC) register: one-cycle capture of accumulatorIn, async active-high reset.
// Optional registered status flags are compiled in with AC_FLAGS_EN.
module accumulator_reg
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH     = AC_WIDTH,
  parameter logic [63:0] RESET_VAL = 64'(AC_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] accumulatorIn,
  output logic [WIDTH-1:0] accumulatorOut
`ifdef AC_FLAGS_EN
  ,
  output logic             acZero,
  output logic             acNeg,
  output logic             acChanged
`endif
);

  localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;

  always_comb begin
    acc_d = accumulatorIn;
  end

  // Reset wins over a coincident capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= RST_WORD;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign accumulatorOut = acc_q;

`ifdef AC_FLAGS_EN
  localparam ac_flags_t RST_FLAGS = '{
    zero:    (RST_WORD == '0),
    neg:     RST_WORD[WIDTH-1],
    changed: 1'b0
  };

  ac_flags_t flags_c;
  ac_flags_t flags_d;
  ac_flags_t flags_q;

  ac_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .value_i (accumulatorIn),
    .prev_i  (acc_q),
    .flags_c (flags_c)
  );

  always_comb begin
    flags_d = flags_c;
  end

  // Registered on the same edge as the data so flags always match accumulatorOut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= RST_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign acZero    = flags_q.zero;
  assign acNeg     = flags_q.neg;
  assign acChanged = flags_q.changed;
`endif

endmodule : accumulator_reg

// File: tb/tb_accumulator_reg.sv
// Directed and randomized bench for accumulator_reg against a behavioural model.
// Flag checks are included when AC_FLAGS_EN is defined.
module tb_accumulator_reg;

  logic        clk;
  logic        rst;
  logic [31:0] accumulatorIn;
  logic [31:0] accumulatorOut;
`ifdef AC_FLAGS_EN
  logic        acZero;
  logic        acNeg;
  logic        acChanged;
`endif

  int vectors;
  int miscompares;

  // Reference model state: what the register should hold after each event.
  logic [31:0] exp_out;
  logic        exp_zero;
  logic        exp_neg;
  logic        exp_chg;

  accumulator_reg dut (
    .clk            (clk),
    .rst            (rst),
    .accumulatorIn  (accumulatorIn),
    .accumulatorOut (accumulatorOut)
`ifdef AC_FLAGS_EN
    ,
    .acZero         (acZero),
    .acNeg          (acNeg),
    .acChanged      (acChanged)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_out  = 32'h0;
    exp_zero = 1'b1;
    exp_neg  = 1'b0;
    exp_chg  = 1'b0;
  endtask

  task automatic model_capture(input logic [31:0] v);
    exp_chg  = (v != exp_out);
    exp_out  = v;
    exp_zero = (v == 32'h0);
    exp_neg  = (v >= 32'h8000_0000);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_out"}, accumulatorOut, exp_out);
`ifdef AC_FLAGS_EN
    chk({tag, "_zero"}, 32'(acZero), 32'(exp_zero));
    chk({tag, "_neg"}, 32'(acNeg), 32'(exp_neg));
    chk({tag, "_chg"}, 32'(acChanged), 32'(exp_chg));
`endif
  endtask

  // Apply a value between edges, then check just after the capturing edge.
  task automatic step(input logic [31:0] v, input string tag);
    @(negedge clk);
    accumulatorIn = v;
    @(posedge clk);
    model_capture(v);
    #1;
    chk_all(tag);
  endtask

  // Release reset and apply a value on the same falling edge.
  task automatic rel_step(input logic [31:0] v, input string tag);
    @(negedge clk);
    rst           = 1'b0;
    accumulatorIn = v;
    @(posedge clk);
    model_capture(v);
    #1;
    chk_all(tag);
  endtask

  // Pulse reset mid-cycle and check it clears the output before any edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] v;
    int unsigned r;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    accumulatorIn = 32'h0;
    model_reset();

    // Reset state before and after the first edge.
    #1;
    chk_all("reset_t1");
    @(posedge clk);
    #1;
    chk_all("reset_edge");

    // Ramp 2,4,...,32 starting at the 10 ns release.
    rel_step(32'd2, "ramp");
    for (int k = 2; k <= 16; k++) begin
      step(32'(2 * k), "ramp");
    end
    chk("ramp_final", accumulatorOut, 32'h20);

    // Asynchronous reset while holding a nonzero value.
    async_reset("async_clear");
    rel_step(32'h10, "latency_a");

    // Mid-cycle input change must not reach the output before the edge.
    #2;
    accumulatorIn = 32'h12;
    #1;
    chk_all("latency_hold");
    @(posedge clk);
    model_capture(32'h12);
    #1;
    chk_all("latency_b");

    // Boundary values, then a repeated value.
    step(32'hFFFF_FFFF, "bound_ones");
    step(32'h8000_0000, "bound_msb");
    step(32'h0000_0000, "bound_zero");
    step(32'h0000_0000, "bound_repeat");

    // Reset coincident with a capture edge.
    @(negedge clk);
    accumulatorIn = 32'h1234;
    @(posedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst_priority");
    rel_step(32'h1234, "rst_release");

    // Randomized values with occasional repeats and reset pulses.
    for (int i = 0; i < 48; i++) begin
      r = $urandom_range(0, 9);
      v = (r == 0) ? exp_out : $urandom;
      if (r == 1) begin
        async_reset("rand_rst");
        rel_step(v, "rand_rel");
      end else begin
        step(v, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_accumulator_reg
